flappy_game_ctrl: RTL and testbench
===================================

# flappy_game_ctrl

Game-sequencing controller for Flappy Bird, sitting between the playfield logic (collision and pipe-pass detection) and the three-digit BCD score counter. It runs the IDLE/PLAY/DYING/OVER state machine and turns pipe passes into one-cycle score increments. It clears the score at the start of each game and keeps a shadow of the score so it can hold a best score across games until reset.

## Interface
Parameters:
- DEATH_TICKS, 16: number of frame ticks spent in DYING, for the fall animation; legal range 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; returns every register to its reset value
- tick  in  1  frame strobe, one-cycle pulse per video frame
- flap  in  1  player button level, already synchronized to clk
- collide  in  1  bird/pipe/ground collision level from the playfield
- pipe_pass  in  1  one-cycle pulse when a pipe's trailing edge crosses the bird column
- score_inc  out  1  one-cycle increment pulse to the score counter's inc input
- score_clr  out  1  one-cycle clear pulse; wired to the score counter's clear (game_over) input
- playing  out  1  high in PLAY; gates bird physics and pipe scrolling
- game_over  out  1  high in OVER; drives the "GAME OVER" overlay only, never the counter clear
- state  out  2  current state: IDLE=0, PLAY=1, DYING=2, OVER=3
- best_a, best_b, best_c  out  4 each  best score in BCD (hundreds, tens, ones)
- new_best  out  1  high in OVER when the last game set a new best

## Operation
Flap edge detection:
- flap_q is a registered copy of flap.
- flap_edge = flap & ~flap_q.
- flap_q resets to 1, so a button held through reset release produces no edge until it has been released.

State machine transitions:
- IDLE: on flap_edge, go to PLAY and pulse score_clr for one cycle.
- PLAY:
  - collide: go to DYING and load the tick counter with DEATH_TICKS. Collision wins over a pipe_pass in the same cycle; that pass is not scored.
  - pipe_pass without collide: pulse score_inc and advance the shadow score.
- DYING:
  - On each tick, decrement the tick counter.
  - On the tick that takes it to 0, go to OVER.
  - flap, collide and pipe_pass are ignored.
- OVER:
  - On entry, compare shadow > best; if greater, copy shadow to best and set new_best.
  - On flap_edge, go to PLAY, pulse score_clr, clear the shadow and clear new_best.

Score shadow and best score:
- Shadow is three BCD digits that increment in step with score_inc.
- Ones digit wraps 9→0 with a carry into tens; tens wraps likewise into hundreds.
- 999+1 wraps to 000.
- Best comparison is lexicographic on (a, b, c).
- Best resets to 000 and is never cleared except by reset.

Reset values:
- state = IDLE; flap_q = 1; tick counter = 0.
- score_inc, score_clr, playing, game_over, new_best = 0.
- best = 000; shadow = 000.

## Timing
- All outputs are registered. Decisions are made on the sampled inputs, and the result appears the cycle after the triggering input.
- score_inc goes high exactly 1 cycle after a sampled pipe_pass, lasts exactly 1 cycle, and is asserted once per pipe_pass pulse.
- score_clr goes high 1 cycle after the sampled flap_edge, in the same cycle that state first reads PLAY.
- Back-to-back pipe_pass on consecutive cycles produces back-to-back score_inc pulses; none are dropped.
- DYING lasts exactly DEATH_TICKS tick pulses, independent of the tick spacing.
- best is updated in the first cycle state reads OVER; new_best and game_over assert in that same cycle.
- An asserted reset in any state forces IDLE immediately (asynchronously), and any pending pulse is discarded.
- A pipe_pass in the same cycle as the IDLE→PLAY or OVER→PLAY transition is ignored.

## Structure
- Shared package flappy_pkg holds:
  - the game_state_e enum (IDLE, PLAY, DYING, OVER; 2 bits);
  - the bcd3_t struct of three 4-bit digits.
- One sub-module, bcd3_inc: a combinational 3-digit BCD increment with wrap. It is used for the shadow score, and the compare lives in the parent.
- The FSM, tick counter, flap edge detector and best register live in flappy_game_ctrl.

## Test plan
- Reset with flap held at 1, then release reset: state stays IDLE. Release flap, press again: state=PLAY, with a single score_clr pulse 1 cycle after the edge.
- In PLAY, 12 pipe_pass pulses, two of them on consecutive cycles: exactly 12 score_inc pulses, each 1 cycle after its pass; shadow = 012.
- Assert collide and pipe_pass in the same cycle: state goes to DYING, no score_inc. With DEATH_TICKS=4, send 4 tick pulses: state=OVER after the 4th, game_over=1, best=012, new_best=1.
- Second game scoring 5: on OVER, best stays 012 and new_best=0. Third game scoring 999 then 1 more: shadow wraps to 000, and best stays 012.
- Assert reset mid-DYING and mid-PLAY: all outputs at reset values in the same cycle, best = 000, state = IDLE.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared types for the Flappy Bird game sequencer: the game-state encoding
// and a three-digit BCD score value.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } game_state_e;

  // Digit a is the hundreds place, so a packed compare of two bcd3_t values
  // orders scores numerically.
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
  } bcd3_t;

endpackage

// File: rtl/bcd3_inc.sv
// Combinational +1 on a three-digit BCD value; 999 wraps to 000.
module bcd3_inc
  import flappy_pkg::*;
(
  input  bcd3_t value,
  output bcd3_t next
);

  always_comb begin
    next = value;
    if (value.c == 4'd9) begin
      next.c = 4'd0;
      if (value.b == 4'd9) begin
        next.b = 4'd0;
        next.a = (value.a == 4'd9) ? 4'd0 : value.a + 4'd1;
      end else begin
        next.b = value.b + 4'd1;
      end
    end else begin
      next.c = value.c + 4'd1;
    end
  end

endmodule

// File: rtl/flappy_game_ctrl.sv
// Flappy Bird game sequencer: IDLE/PLAY/DYING/OVER control, score pulses
// toward the external BCD counter, and a best-score register held until reset.
module flappy_game_ctrl
  import flappy_pkg::*;
#(
  parameter int unsigned DEATH_TICKS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       flap,
  input  logic       collide,
  input  logic       pipe_pass,
  output logic       score_inc,
  output logic       score_clr,
  output logic       playing,
  output logic       game_over,
  output logic [1:0] state,
  output logic [3:0] best_a,
  output logic [3:0] best_b,
  output logic [3:0] best_c,
  output logic       new_best
);

  localparam logic [7:0] TICKS_INIT = 8'(DEATH_TICKS);

  game_state_e state_q, state_d;
  logic [7:0]  tick_q, tick_d;
  logic        flap_q;
  logic        flap_edge;
  logic        inc_d, clr_d, new_best_d;
  bcd3_t       shadow_q, shadow_d, shadow_next;
  bcd3_t       best_q, best_d;

  assign flap_edge = flap & ~flap_q;

  bcd3_inc u_shadow_inc (
    .value (shadow_q),
    .next  (shadow_next)
  );

  // NOTE: every signal gets its hold value before the case statement, so no
  // path through this block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    inc_d      = 1'b0;
    clr_d      = 1'b0;
    new_best_d = new_best;
    shadow_d   = shadow_q;
    best_d     = best_q;
    unique case (state_q)
      IDLE, OVER: begin
        if (flap_edge) begin
          state_d    = PLAY;
          clr_d      = 1'b1;
          shadow_d   = '0;
          new_best_d = 1'b0;
        end
      end
      PLAY: begin
        // A collision in the same cycle as a pass ends the game unscored.
        if (collide) begin
          state_d = DYING;
          tick_d  = TICKS_INIT;
        end else if (pipe_pass) begin
          inc_d    = 1'b1;
          shadow_d = shadow_next;
        end
      end
      DYING: begin
        if (tick) begin
          tick_d = tick_q - 8'd1;
          if (tick_q <= 8'd1) begin
            state_d    = OVER;
            new_best_d = (shadow_q > best_q);
            if (shadow_q > best_q) best_d = shadow_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      flap_q    <= 1'b1;
      score_inc <= 1'b0;
      score_clr <= 1'b0;
      playing   <= 1'b0;
      game_over <= 1'b0;
      new_best  <= 1'b0;
      shadow_q  <= '0;
      best_q    <= '0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      flap_q    <= flap;
      score_inc <= inc_d;
      score_clr <= clr_d;
      playing   <= (state_d == PLAY);
      game_over <= (state_d == OVER);
      new_best  <= new_best_d;
      shadow_q  <= shadow_d;
      best_q    <= best_d;
    end
  end

  assign state  = state_q;
  assign best_a = best_q.a;
  assign best_b = best_q.b;
  assign best_c = best_q.c;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Self-checking bench for flappy_game_ctrl: integer-level game model checked
// every cycle, plus directed games with hand-computed expectations.
module tb_flappy_game_ctrl;

  localparam int DT = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0, flap = 1'b1, collide = 1'b0, pipe_pass = 1'b0;
  logic       score_inc, score_clr, playing, game_over, new_best;
  logic [1:0] state;
  logic [3:0] best_a, best_b, best_c;

  int tests = 0;
  int fails = 0;
  int inc_count = 0;

  always #5 clk = ~clk;

  flappy_game_ctrl #(.DEATH_TICKS(DT)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .flap      (flap),
    .collide   (collide),
    .pipe_pass (pipe_pass),
    .score_inc (score_inc),
    .score_clr (score_clr),
    .playing   (playing),
    .game_over (game_over),
    .state     (state),
    .best_a    (best_a),
    .best_b    (best_b),
    .best_c    (best_c),
    .new_best  (new_best)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Game model: scores are plain integers 0..999, the phase is a number.
  int m_state, m_score, m_best, m_left;
  bit m_fprev, m_inc, m_clr, m_nb, m_fe;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state <= 0; m_score <= 0; m_best <= 0; m_left <= 0;
      m_fprev <= 1'b1; m_inc <= 1'b0; m_clr <= 1'b0; m_nb <= 1'b0;
    end else begin
      m_fe = flap && !m_fprev;
      m_fprev <= flap;
      m_inc <= 1'b0;
      m_clr <= 1'b0;
      if ((m_state == 0 || m_state == 3) && m_fe) begin
        m_state <= 1; m_clr <= 1'b1; m_score <= 0; m_nb <= 1'b0;
      end else if (m_state == 1) begin
        if (collide) begin
          m_state <= 2; m_left <= DT;
        end else if (pipe_pass) begin
          m_inc <= 1'b1; m_score <= (m_score + 1) % 1000;
        end
      end else if (m_state == 2 && tick) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_state <= 3;
          m_nb <= (m_score > m_best);
          if (m_score > m_best) m_best <= m_score;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("state", state, m_state);
      check("playing", playing, m_state == 1);
      check("game_over", game_over, m_state == 3);
      check("score_inc", score_inc, m_inc);
      check("score_clr", score_clr, m_clr);
      check("new_best", new_best, m_nb);
      check("best_a", best_a, m_best / 100);
      check("best_b", best_b, (m_best / 10) % 10);
      check("best_c", best_c, m_best % 10);
      if (score_inc) inc_count++;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_game();
    flap = 1'b0; cyc();
    flap = 1'b1; cyc();
    check("start_state", state, 1);
    check("start_clr", score_clr, 1);
    flap = 1'b0; cyc();
    check("start_clr_single", score_clr, 0);
  endtask

  task automatic pass_pipes(input int n);
    for (int i = 0; i < n; i++) begin
      pipe_pass = 1'b1; cyc();
      check("inc_after_pass", score_inc, 1);
      pipe_pass = 1'b0; cyc();
      check("inc_one_cycle", score_inc, 0);
    end
  endtask

  task automatic die();
    collide = 1'b1; cyc();
    collide = 1'b0;
    check("dying_state", state, 2);
    for (int i = 0; i < DT; i++) begin
      tick = 1'b1; cyc();
      tick = 1'b0;
      check("dying_len", state, (i == DT - 1) ? 3 : 2);
      cyc(i % 3);
    end
  endtask

  task automatic check_best(input int a, input int b, input int c, input int nb);
    check("over_state", state, 3);
    check("over_flag", game_over, 1);
    check("best_a_lit", best_a, a);
    check("best_b_lit", best_b, b);
    check("best_c_lit", best_c, c);
    check("new_best_lit", new_best, nb);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_inc"}, score_inc, 0);
    check({tag, "_clr"}, score_clr, 0);
    check({tag, "_playing"}, playing, 0);
    check({tag, "_over"}, game_over, 0);
    check({tag, "_newbest"}, new_best, 0);
    check({tag, "_best"}, {best_a, best_b, best_c}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    #1 reset = 1'b1;
    cyc(3);
    check_reset_outputs("reset");
    reset = 1'b0;
    cyc(3);
    check("held_flap_idle", state, 0);

    // Game 1: twelve passes, two of them back to back.
    start_game();
    base = inc_count;
    pass_pipes(5);
    pipe_pass = 1'b1; cyc();
    check("b2b_inc1", score_inc, 1);
    cyc();
    check("b2b_inc2", score_inc, 1);
    pipe_pass = 1'b0; cyc();
    pass_pipes(5);
    check("inc_count_12", inc_count - base, 12);
    pipe_pass = 1'b1;
    collide = 1'b1; cyc();
    pipe_pass = 1'b0;
    collide = 1'b0;
    check("collide_wins_inc", score_inc, 0);
    check("collide_wins_state", state, 2);
    cyc();
    for (int i = 0; i < DT; i++) begin
      tick = 1'b1; cyc();
      tick = 1'b0;
      cyc(2);
    end
    check_best(0, 1, 2, 1);

    // Game 2: five points does not beat twelve.
    start_game();
    check("restart_newbest_clr", new_best, 0);
    pass_pipes(5);
    die();
    check_best(0, 1, 2, 0);

    // Game 3: 1000 consecutive passes wrap the score back to 000.
    start_game();
    base = inc_count;
    pipe_pass = 1'b1; cyc(1000);
    pipe_pass = 1'b0; cyc();
    check("inc_count_1000", inc_count - base, 1000);
    die();
    check_best(0, 1, 2, 0);

    // Game 4: thirteen beats twelve on the ones digit.
    start_game();
    pass_pipes(13);
    die();
    check_best(0, 1, 3, 1);

    // Reset mid-DYING, asynchronously.
    start_game();
    collide = 1'b1; cyc();
    collide = 1'b0;
    tick = 1'b1; cyc();
    tick = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_dying");
    cyc();
    reset = 1'b0;
    cyc(2);

    // Reset mid-PLAY with a score_inc pulse in flight.
    start_game();
    pass_pipes(3);
    pipe_pass = 1'b1; cyc();
    pipe_pass = 1'b0;
    check("pre_reset_inc", score_inc, 1);
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_play");
    cyc();
    reset = 1'b0;
    cyc(3);
    check("post_reset_idle", state, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
